// File: rtl/swd_phy.sv
`default_nettype none
// ============================================================================
//  Module   : swd_phy
//  Purpose  : Serial Wire Debug physical layer. Synchronises SWCLK/SWDIO into
//             the HCLK domain, deglitches SWCLK, reports accepted edges,
//             launches SWDIO output data on SWCLK falling edges and detects
//             SWD line resets (a long run of 1-bits).
//  Revision : 1.0  initial release
// ============================================================================
module swd_phy #(
   parameter int SYNC_STAGES = 2,   // synchroniser depth per async input (2..4)
   parameter int FILT_LEN    = 3,   // agreeing samples to accept an SWCLK change (1..8)
   parameter int LRST_BITS   = 50   // 1-bits forming a line reset (2..255)
) (
   input  logic HCLK,
   input  logic HRESET,
   input  logic SWCLK_I,
   input  logic SWDIO_I,
   output logic SWDIO_O,
   output logic SWDIO_OE,
   input  logic tx_bit,
   input  logic tx_en,
   output logic rx_valid,
   output logic rx_bit,
   output logic clk_fall,
   output logic line_reset
);

   localparam int             CW        = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0]  FILT_LAST = CW'(FILT_LEN - 1);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam logic [7:0]     LRST_MAX  = 8'(LRST_BITS);

   logic [SYNC_STAGES-1:0] swclk_sync_q;
   logic [SYNC_STAGES-1:0] swdio_sync_q;
   logic                   swclk_s;
   logic                   swdio_s;

   logic                   filt_q,  filt_d;
   logic [CW-1:0]          fcnt_q,  fcnt_d;
   logic                   rise_d,  fall_d;

   logic                   rx_valid_q, rx_bit_q, clk_fall_q;
   logic                   swdio_o_q, swdio_oe_q;
   logic [7:0]             lrc_q,   lrc_d;
   logic                   lr_q,    lr_d;

   // Synchroniser chains: the only logic that touches the raw pins.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         swclk_sync_q <= '0;
         swdio_sync_q <= '0;
      end else begin
         swclk_sync_q <= {swclk_sync_q[SYNC_STAGES-2:0], SWCLK_I};
         swdio_sync_q <= {swdio_sync_q[SYNC_STAGES-2:0], SWDIO_I};
      end
   end

   assign swclk_s = swclk_sync_q[SYNC_STAGES-1];
   assign swdio_s = swdio_sync_q[SYNC_STAGES-1];

   // Deglitch filter: follow SWCLK only after FILT_LEN consecutive disagreeing
   // samples; the counter stops at FILT_LEN-1 so it can never wrap.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (swclk_s != filt_q) begin
         if (fcnt_q == FILT_LAST) begin
            filt_d = swclk_s;
         end else begin
            fcnt_d = fcnt_q + CNT_ONE;
         end
      end
      rise_d = filt_d & ~filt_q;
      fall_d = ~filt_d & filt_q;
   end

   // Line-reset run counter: counts sampled 1-bits, saturating, and flags the
   // single step into saturation.
   always_comb begin
      lrc_d = lrc_q;
      lr_d  = 1'b0;
      if (rx_valid_q) begin
         if (rx_bit_q) begin
            if (lrc_q != LRST_MAX) begin
               lrc_d = lrc_q + 8'd1;
               lr_d  = (lrc_q == (LRST_MAX - 8'd1));
            end
         end else begin
            lrc_d = '0;
         end
      end
   end

   // Edge strobes, captured data, pad drive and line-reset state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         filt_q     <= 1'b0;
         fcnt_q     <= '0;
         rx_valid_q <= 1'b0;
         rx_bit_q   <= 1'b0;
         clk_fall_q <= 1'b0;
         swdio_o_q  <= 1'b0;
         swdio_oe_q <= 1'b0;
         lrc_q      <= '0;
         lr_q       <= 1'b0;
      end else begin
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         rx_valid_q <= rise_d;
         clk_fall_q <= fall_d;
         if (rise_d) begin
            rx_bit_q <= swdio_s;
         end
         // Pad only changes on a falling SWCLK so turnaround never cuts a bit.
         if (fall_d) begin
            swdio_oe_q <= tx_en;
            swdio_o_q  <= tx_en & tx_bit;
         end
         lrc_q <= lrc_d;
         lr_q  <= lr_d;
      end
   end

   assign rx_valid   = rx_valid_q;
   assign rx_bit     = rx_bit_q;
   assign clk_fall   = clk_fall_q;
   assign SWDIO_O    = swdio_o_q;
   assign SWDIO_OE   = swdio_oe_q;
   assign line_reset = lr_q;

endmodule
`default_nettype wire

// File: tb/tb_swd_phy.sv
`default_nettype none
// ============================================================================
//  Module   : tb_swd_phy
//  Purpose  : Self-checking bench for swd_phy. A cycle-level reference model
//             built from queues (synchroniser delay, sample window, 1-bit run
//             length) predicts every output each HCLK cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_swd_phy;

   localparam int SYNC = 2;
   localparam int FILT = 3;
   localparam int LRST = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic swclk = 1'b0;
   logic swdio = 1'b0;
   logic tx_bit = 1'b0;
   logic tx_en = 1'b0;
   logic swdio_o, swdio_oe, rx_valid, rx_bit, clk_fall, line_reset;

   int checks = 0;
   int errors = 0;
   int lr_seen = 0;
   int rxv_seen = 0;
   int fall_seen = 0;

   // Reference model state
   bit mq_clk[$];
   bit mq_dio[$];
   bit win[$];
   bit m_filt;
   bit e_rxv, e_rxb, e_fall, e_o, e_oe, e_lr;
   int ones;

   swd_phy #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .LRST_BITS(LRST)) dut (
      .HCLK       (clk),
      .HRESET     (rst),
      .SWCLK_I    (swclk),
      .SWDIO_I    (swdio),
      .SWDIO_O    (swdio_o),
      .SWDIO_OE   (swdio_oe),
      .tx_bit     (tx_bit),
      .tx_en      (tx_en),
      .rx_valid   (rx_valid),
      .rx_bit     (rx_bit),
      .clk_fall   (clk_fall),
      .line_reset (line_reset)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq_clk.delete();
      mq_dio.delete();
      win.delete();
      for (int i = 0; i < SYNC; i++) begin
         mq_clk.push_back(1'b0);
         mq_dio.push_back(1'b0);
      end
      m_filt = 0; ones = 0;
      e_rxv = 0; e_rxb = 0; e_fall = 0; e_o = 0; e_oe = 0; e_lr = 0;
   endtask

   // Advance the model by one HCLK edge using the inputs seen at that edge.
   task automatic model_edge();
      bit s_clk, s_dio, rise, fall;
      if (rst) begin
         model_clear();
      end else begin
         rise = 0; fall = 0;
         e_lr = 0;
         if (e_rxv) begin
            if (e_rxb) begin
               if (ones < LRST) begin
                  ones++;
                  if (ones == LRST) e_lr = 1;
               end
            end else begin
               ones = 0;
            end
         end
         s_clk = mq_clk.pop_front();
         s_dio = mq_dio.pop_front();
         mq_clk.push_back(swclk);
         mq_dio.push_back(swdio);
         if (s_clk != m_filt) begin
            win.push_back(s_clk);
            if (win.size() == FILT) begin
               m_filt = s_clk;
               win.delete();
               rise = m_filt;
               fall = !m_filt;
            end
         end else begin
            win.delete();
         end
         e_rxv  = rise;
         e_fall = fall;
         if (rise) e_rxb = s_dio;
         if (fall) begin
            e_oe = tx_en;
            e_o  = tx_en & tx_bit;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("rx_valid",   rx_valid,   e_rxv);
      chk("rx_bit",     rx_bit,     e_rxb);
      chk("clk_fall",   clk_fall,   e_fall);
      chk("swdio_o",    swdio_o,    e_o);
      chk("swdio_oe",   swdio_oe,   e_oe);
      chk("line_reset", line_reset, e_lr);
      if (line_reset === 1'b1) lr_seen++;
      if (rx_valid === 1'b1) rxv_seen++;
      if (clk_fall === 1'b1) fall_seen++;
   endtask

   task automatic send_bit(input bit b, input int half);
      swclk = 1'b0;
      swdio = b;
      repeat (half) tick();
      swclk = 1'b1;
      repeat (half) tick();
   endtask

   task automatic flush();
      swclk = 1'b0;
      repeat (8) tick();
   endtask

   task automatic wait_fall(output bit ok);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         if (clk_fall === 1'b1) ok = 1;
      end
   endtask

   initial begin
      int n;
      bit found;
      bit ok;
      int half;
      model_clear();

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_oe", swdio_oe, 0);
      rst = 1'b0;
      repeat (10) tick();

      // Edge latency: 10-cycle half periods, SWDIO high
      swdio = 1'b1;
      for (int p = 0; p < 6; p++) begin
         swclk = 1'b1;
         n = 0; found = 0;
         for (int i = 0; i < 20 && !found; i++) begin
            tick(); n++;
            if (rx_valid === 1'b1) found = 1;
         end
         chk("lat_rise", n, SYNC + FILT);
         chk("lat_rx_bit", rx_bit, 1);
         if (n < 10) repeat (10 - n) tick();
         swclk = 1'b0;
         n = 0; found = 0;
         for (int i = 0; i < 20 && !found; i++) begin
            tick(); n++;
            if (clk_fall === 1'b1) found = 1;
         end
         chk("lat_fall", n, SYNC + FILT);
         if (n < 10) repeat (10 - n) tick();
      end

      // Short SWCLK glitch is rejected
      rxv_seen = 0; fall_seen = 0;
      swclk = 1'b1;
      repeat (2) tick();
      swclk = 1'b0;
      repeat (15) tick();
      chk("glitch_rxv", rxv_seen, 0);
      chk("glitch_fall", fall_seen, 0);

      // Drive then turnaround only on falling edges
      tx_en = 1'b1; tx_bit = 1'b1;
      send_bit(1'b0, 6);
      swclk = 1'b0;
      wait_fall(ok);
      chk("tx_fall_seen", ok, 1);
      chk("tx_oe_on", swdio_oe, 1);
      chk("tx_o_on", swdio_o, 1);
      tx_en = 1'b0;
      repeat (4) tick();
      swclk = 1'b1;
      repeat (10) begin
         tick();
         chk("tx_oe_hold", swdio_oe, 1);
      end
      swclk = 1'b0;
      wait_fall(ok);
      chk("tx_fall2_seen", ok, 1);
      chk("tx_oe_off", swdio_oe, 0);
      chk("tx_o_off", swdio_o, 0);

      // Line reset: 50 ones -> one pulse, 10 more -> none, 0 + 50 -> another
      send_bit(1'b0, 5);
      lr_seen = 0;
      repeat (LRST) send_bit(1'b1, 5);
      flush();
      chk("lr_first", lr_seen, 1);
      repeat (10) send_bit(1'b1, 5);
      flush();
      chk("lr_no_repeat", lr_seen, 1);
      send_bit(1'b0, 5);
      repeat (LRST) send_bit(1'b1, 5);
      flush();
      chk("lr_second", lr_seen, 2);

      // 49 ones, a zero, 49 ones -> no line reset
      send_bit(1'b0, 5);
      lr_seen = 0;
      repeat (LRST - 1) send_bit(1'b1, 5);
      send_bit(1'b0, 5);
      repeat (LRST - 1) send_bit(1'b1, 5);
      flush();
      chk("lr_interrupted", lr_seen, 0);

      // Reset while driving with a partial run of 30 ones
      send_bit(1'b0, 5);
      tx_en = 1'b1; tx_bit = 1'b1;
      repeat (30) send_bit(1'b1, 5);
      swclk = 1'b0;
      repeat (7) tick();
      chk("pre_rst_oe", swdio_oe, 1);
      rst = 1'b1;
      tick();
      chk("rst_oe", swdio_oe, 0);
      chk("rst_o", swdio_o, 0);
      chk("rst_lr", line_reset, 0);
      rst = 1'b0;
      tx_en = 1'b0;
      lr_seen = 0;
      repeat (LRST - 1) send_bit(1'b1, 5);
      flush();
      chk("rst_lr_fresh49", lr_seen, 0);
      send_bit(1'b1, 5);
      flush();
      chk("rst_lr_fresh50", lr_seen, 1);

      // SWCLK high while reset releases reports a normal rising edge
      swclk = 1'b1;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      rxv_seen = 0;
      repeat (10) tick();
      chk("rst_high_rxv", rxv_seen, 1);

      // Randomised traffic with glitches and occasional resets
      for (int k = 0; k < 300; k++) begin
         half   = $urandom_range(3, 8);
         tx_en  = 1'($urandom_range(0, 1));
         tx_bit = 1'($urandom_range(0, 1));
         swclk  = 1'b0;
         swdio  = 1'($urandom_range(0, 1));
         repeat (half) tick();
         if ($urandom_range(0, 3) == 0) begin
            swclk = 1'b1;
            repeat ($urandom_range(1, 2)) tick();
            swclk = 1'b0;
            repeat (half) tick();
         end
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         swclk = 1'b1;
         repeat (half) tick();
      end
      flush();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
